// File: rtl/uart_eval_pkg.sv
// Shared definitions for the UART evaluation sequencer.
//   state_t   : sequencer FSM states
//   CMD_*     : command bytes recognised in IDLE
//   CHAR_*    : ASCII characters emitted on the TX stream
//   bit_char  : maps one result bit to '0' / '1'
package uart_eval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND,
        ST_TERM
    } state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h80;
    localparam logic [7:0] CMD_EVAL  = 8'h81;
    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_TERM = 8'h2A;

    function automatic logic [7:0] bit_char(input logic b);
        return CHAR_ZERO | {7'd0, b};
    endfunction

endpackage

// File: rtl/uart_eval_tx_ser.sv
// Result serializer: captures the core output into a shadow register and
// streams it LSB first as ASCII '0'/'1', followed by a '*' terminator.
// Ports:
//   clk_48mhz, reset_n : clock, async active-low reset
//   load, data         : capture data into shadow (one-cycle pulse)
//   tx_data, tx_valid  : registered character stream, held until accepted
//   tx_ready           : downstream accept
//   bits_done          : pulse when the last result bit is accepted
//   done               : pulse when the terminator is accepted
module uart_eval_tx_ser
    import uart_eval_pkg::*;
#(
    parameter int OL = 64
) (
    input  logic          clk_48mhz,
    input  logic          reset_n,
    input  logic          load,
    input  logic [OL-1:0] data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          bits_done,
    output logic          done
);
    localparam int CW = $clog2(OL + 1);

    logic [OL-1:0] shadow;
    logic [CW-1:0] cursor;
    logic [CW-1:0] nxt;
    logic [OL-1:0] sh_nxt;
    logic          start;
    logic          in_term;
    logic          accept;

    assign accept    = tx_valid & tx_ready;
    assign nxt       = cursor + CW'(1);
    // Shift instead of a variable bit-select so the index width never has to
    // match the shadow width exactly.
    assign sh_nxt    = shadow >> nxt;
    assign bits_done = accept & ~in_term & (cursor == CW'(OL - 1));
    assign done      = accept & in_term;

    // cursor always names the bit currently presented on tx_data, so the next
    // character is loaded on the accepting edge and there is no bubble.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            shadow   <= '0;
            cursor   <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            start    <= 1'b0;
            in_term  <= 1'b0;
        end else begin
            start <= load;
            if (load) begin
                shadow <= data;
                cursor <= '0;
            end else if (start) begin
                tx_valid <= 1'b1;
                tx_data  <= bit_char(shadow[0]);
            end else if (accept) begin
                if (in_term) begin
                    tx_valid <= 1'b0;
                    in_term  <= 1'b0;
                end else begin
                    cursor <= nxt;
                    if (cursor == CW'(OL - 1)) begin
                        tx_data <= CHAR_TERM;
                        in_term <= 1'b1;
                    end else begin
                        tx_data <= bit_char(sh_nxt[0]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_eval_sequencer.sv
// Request-driven controller between the usb_uart byte pipeline and the
// combinational evaluation core. Received bytes edit eval_in bit by bit;
// an evaluate command settles, captures eval_out and streams it back as
// ASCII '0'/'1' characters terminated by '*'.
// Ports:
//   clk_48mhz, reset_n       : clock, async active-low reset
//   rx_data/rx_valid/rx_ready: command byte input (accepted only in IDLE)
//   tx_data/tx_valid/tx_ready: result character output
//   eval_in / eval_out       : registered core input / core result
//   busy                     : high whenever not IDLE
//   rx_seen                  : sticky, set by the first accepted byte
// Build option: UART_EVAL_AUTO_EN -- bit writes and clears also start an
// evaluation, exactly like the evaluate command.
module uart_eval_sequencer
    import uart_eval_pkg::*;
#(
    parameter int IL     = 64,
    parameter int OL     = 64,
    parameter int SETTLE = 4
) (
    input  logic          clk_48mhz,
    input  logic          reset_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [IL-1:0] eval_in,
    input  logic [OL-1:0] eval_out,
    output logic          busy,
    output logic          rx_seen
);
    localparam int SW = $clog2(SETTLE + 1);

    state_t        state, state_nxt;
    logic [SW-1:0] cnt;
    logic          rx_fire, is_write, wr_hit, is_clear, is_eval, start_eval;
    logic          load, bits_done, done;
    logic [IL-1:0] mask;

    assign rx_ready = (state == ST_IDLE);
    assign busy     = ~rx_ready;
    assign rx_fire  = rx_valid & rx_ready;
    assign is_write = ~rx_data[7];
    assign wr_hit   = is_write && (int'(rx_data[6:1]) < IL);
    assign is_clear = (rx_data == CMD_CLEAR);
    assign is_eval  = (rx_data == CMD_EVAL);
    assign mask     = IL'(1) << rx_data[6:1];
    assign load     = (state == ST_CAPTURE);

`ifdef UART_EVAL_AUTO_EN
    // Any write byte triggers, even one whose index is out of range.
    assign start_eval = rx_fire & (is_eval | is_write | is_clear);
`else
    assign start_eval = rx_fire & is_eval;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start_eval) state_nxt = ST_SETTLE;
            ST_SETTLE:  if (cnt == '0) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_SEND;
            ST_SEND:    if (bits_done) state_nxt = ST_TERM;
            ST_TERM:    if (done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            eval_in <= '0;
            rx_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_eval)
                cnt <= SW'(SETTLE - 1);
            else if (state == ST_SETTLE && cnt != '0)
                cnt <= cnt - SW'(1);
            if (rx_fire) begin
                rx_seen <= 1'b1;
                if (wr_hit)
                    eval_in <= rx_data[0] ? (eval_in | mask) : (eval_in & ~mask);
                else if (is_clear)
                    eval_in <= '0;
            end
        end
    end

    uart_eval_tx_ser #(.OL(OL)) u_tx (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .load      (load),
        .data      (eval_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bits_done (bits_done),
        .done      (done)
    );

endmodule

// File: tb/tb_uart_eval_sequencer.sv
// Directed bench for uart_eval_sequencer (IL=32, OL=64, SETTLE=4).
// eval_out either mirrors eval_in (zero-extended) or is forced by the bench.
module tb_uart_eval_sequencer;
    localparam int IL     = 32;
    localparam int OL     = 64;
    localparam int SETTLE = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [IL-1:0] eval_in;
    logic [OL-1:0] eval_out;
    logic          busy;
    logic          rx_seen;

    logic          eval_mode;
    logic [OL-1:0] eval_force;

    int total = 0;
    int bad   = 0;
    int f_n, f_err, stall_err, leak, lat;

    assign eval_out = eval_mode ? eval_force : {{(OL-IL){1'b0}}, eval_in};

    always #5 clk = ~clk;

    uart_eval_sequencer #(.IL(IL), .OL(OL), .SETTLE(SETTLE)) dut (
        .clk_48mhz (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .eval_in   (eval_in),
        .eval_out  (eval_out),
        .busy      (busy),
        .rx_seen   (rx_seen)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte and hold it until the edge that accepts it.
    task automatic send_rx(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rx_ready_before_send", {63'd0, rx_ready}, 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Edges from now until tx_valid is seen (bounded).
    task automatic wait_tx(output int k);
        k = 0;
        while (!tx_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    // Consume one frame with tx_ready high, comparing each character with the
    // expected bit pattern. Optionally stall 10 cycles after stall_at accepts.
    task automatic run_frame(input logic [63:0] bits, input int stall_at);
        int n, cyc;
        logic [7:0] d0, expc;
        logic fin, stalled;
        n = 0; cyc = 0; fin = 1'b0; stalled = 1'b0;
        f_err = 0; stall_err = 0; leak = 0;
        tx_ready = 1'b1;
        while (!fin && cyc < 2000) begin
            if (rx_valid && rx_ready) leak++;
            if (tx_valid && n == stall_at && !stalled) begin
                stalled  = 1'b1;
                tx_ready = 1'b0;
                d0 = tx_data;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (!tx_valid || tx_data !== d0) stall_err++;
                    if (rx_ready) leak++;
                end
                tx_ready = 1'b1;
            end
            if (tx_valid) begin
                expc = (n < OL) ? (bits[n[5:0]] ? 8'h31 : 8'h30) : 8'h2A;
                if (tx_data !== expc) f_err++;
                n++;
                if (tx_data == 8'h2A) fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        f_n = n;
    endtask

    initial begin
        reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        eval_mode = 1'b0; eval_force = '0;
        #22;
        chk("rst_eval_in",  {32'd0, eval_in}, 64'd0);
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_tx_data",  {56'd0, tx_data}, 64'd0);
        chk("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_rx_seen",  {63'd0, rx_seen}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame: bit 1 set, then evaluate.
        send_rx(8'h03);
        chk("wr_bit1", {32'd0, eval_in}, 64'h2);
        chk("rx_seen_set", {63'd0, rx_seen}, 64'd1);
        send_rx(8'h81);
        chk("eval_busy", {63'd0, busy}, 64'd1);
        chk("eval_rx_ready", {63'd0, rx_ready}, 64'd0);
        wait_tx(lat);
        chk("first_tx_latency", lat, SETTLE + 2);
        run_frame(64'h2, -1);
        chk("f1_len", f_n, OL + 1);
        chk("f1_chars", f_err, 0);
        chk("f1_rx_ready_after", {63'd0, rx_ready}, 64'd1);
        chk("f1_tx_valid_after", {63'd0, tx_valid}, 64'd0);

        // Decode: discarded bytes, top in-range bit, clear.
        send_rx(8'hFE);
        chk("discard_FE", {32'd0, eval_in}, 64'h2);
        send_rx(8'h51);
        chk("discard_idx40", {32'd0, eval_in}, 64'h2);
        send_rx(8'h3F);
        chk("wr_bit31", {32'd0, eval_in}, 64'h8000_0002);
        send_rx(8'h85);
        chk("discard_85", {32'd0, eval_in}, 64'h8000_0002);
        send_rx(8'h80);
        chk("clear", {32'd0, eval_in}, 64'd0);

        // Backpressure with a byte waiting upstream.
        send_rx(8'h01);
        send_rx(8'h0B);
        chk("wr_bit0_bit5", {32'd0, eval_in}, 64'h21);
        send_rx(8'h81);
        rx_data = 8'h05; rx_valid = 1'b1;
        wait_tx(lat);
        chk("f2_latency", lat, SETTLE + 2);
        run_frame(64'h21, 5);
        chk("f2_len", f_n, OL + 1);
        chk("f2_chars", f_err, 0);
        chk("f2_stall_stable", stall_err, 0);
        chk("f2_rx_not_taken", leak, 0);
        chk("f2_eval_in_held", {32'd0, eval_in}, 64'h21);
        chk("f2_rx_ready_after", {63'd0, rx_ready}, 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("f2_pending_byte", {32'd0, eval_in}, 64'h25);

        // eval_out changes after capture must not reach the frame.
        eval_mode = 1'b1; eval_force = '1;
        send_rx(8'h81);
        wait_tx(lat);
        eval_force = '0;
        run_frame('1, -1);
        chk("f3_len", f_n, OL + 1);
        chk("f3_chars", f_err, 0);
        eval_mode = 1'b0;

        // Reset in the middle of SEND, then a fresh frame.
        send_rx(8'h81);
        wait_tx(lat);
        tx_ready = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("f4_cursor20_valid", {63'd0, tx_valid}, 64'd1);
        chk("f4_cursor20_char", {56'd0, tx_data}, 64'h30);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("mid_rst_eval_in", {32'd0, eval_in}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_rx_seen", {63'd0, rx_seen}, 64'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_rx(8'h81);
        wait_tx(lat);
        chk("f5_latency", lat, SETTLE + 2);
        run_frame(64'd0, -1);
        chk("f5_len", f_n, OL + 1);
        chk("f5_chars", f_err, 0);

`ifdef UART_EVAL_AUTO_EN
        send_rx(8'h01);
        wait_tx(lat);
        chk("auto_latency", lat, SETTLE + 2);
        run_frame(64'h1, -1);
        chk("auto_len", f_n, OL + 1);
        chk("auto_chars", f_err, 0);
`else
        send_rx(8'h01);
        chk("noauto_wr", {32'd0, eval_in}, 64'h1);
        chk("noauto_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("noauto_no_tx", {63'd0, tx_valid}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
